// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD countdown controller: preset, prescaled decrement with borrow, pause/abort, done pulse.
// Latency: digits load one edge after start; i-th decrement lands PRESCALE*i edges after the start edge.
// Backpressure: none; pause freezes the prescaler and digits, abort cancels and clears at the next edge.
module bcd_countdown_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_ones,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Prescaler is 8 bits wide so any PRESCALE in 1..255 fits; wrap point precomputed.
  localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] presc;
  logic [7:0] presc_nxt;
  logic [3:0] tens_nxt;
  logic [3:0] ones_nxt;
  logic       err_nxt;
  logic       count_en;
  logic       preset_bad;
  logic       preset_zero;

  assign preset_bad  = (d_tens > 4'd9) || (d_ones > 4'd9);
  assign preset_zero = (d_tens == 4'd0) && (d_ones == 4'd0);

  // Next-state, digit and prescaler decisions; abort beats pause beats counting.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tens_nxt  = q_tens;
    ones_nxt  = q_ones;
    err_nxt   = err;
    count_en  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (preset_bad) begin
            err_nxt = 1'b1;
          end else begin
            tens_nxt  = d_tens;
            ones_nxt  = d_ones;
            presc_nxt = 8'd0;
            err_nxt   = 1'b0;
            state_nxt = preset_zero ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          presc_nxt = 8'd0;
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = HOLD;
        end else begin
          count_en = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
          presc_nxt = 8'd0;
          state_nxt = IDLE;
        end else if (!pause) begin
          // The release edge counts, so a HOLD stretch costs exactly its own length.
          count_en  = 1'b1;
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (count_en) begin
      if (presc == PS_MAX) begin
        presc_nxt = 8'd0;
        if (q_ones != 4'd0) begin
          ones_nxt = q_ones - 4'd1;
        end else begin
          ones_nxt = 4'd9;
          tens_nxt = q_tens - 4'd1;
        end
        // A tick from 01 lands on 00: finish on the same edge, never wrap to 99.
        if ((q_tens == 4'd0) && (q_ones == 4'd1)) begin
          state_nxt = DONE;
        end
      end else begin
        presc_nxt = presc + 8'd1;
      end
    end
  end

  // State, datapath and registered status outputs; mr clears everything at once.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state  <= IDLE;
      presc  <= 8'd0;
      q_tens <= 4'd0;
      q_ones <= 4'd0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      q_tens <= tens_nxt;
      q_ones <= ones_nxt;
      err    <= err_nxt;
      busy   <= (state_nxt == RUN) || (state_nxt == HOLD);
      done   <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Bench for bcd_countdown_ctrl: two instances (PRESCALE=4 and PRESCALE=1) sharing most inputs.
// The PRESCALE=4 instance is tracked every cycle by an integer-valued reference model feeding a queue.
// Scenario tasks add targeted inline checks on timing, precedence and error handling.
module tb_bcd_countdown_ctrl;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] d_tens = 4'd0;
  logic [3:0] d_ones = 4'd0;

  logic [3:0] q_tens4, q_ones4, q_tens1, q_ones1;
  logic       busy4, done4, err4, busy1, done1, err1;

  bcd_countdown_ctrl #(.PRESCALE(4)) dut4 (
    .clk(clk), .mr(mr), .start(start4), .pause(pause), .abort(abort),
    .d_tens(d_tens), .d_ones(d_ones), .q_tens(q_tens4), .q_ones(q_ones4),
    .busy(busy4), .done(done4), .err(err4)
  );

  bcd_countdown_ctrl #(.PRESCALE(1)) dut1 (
    .clk(clk), .mr(mr), .start(start1), .pause(pause), .abort(abort),
    .d_tens(d_tens), .d_ones(d_ones), .q_tens(q_tens1), .q_ones(q_ones1),
    .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
    logic       d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  bit   sb_on = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model of the PRESCALE=4 instance: whole value as an integer, states 0..3.
  int m_st = 0;
  int m_val = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;

  always @(posedge clk or posedge mr) begin
    exp_t x;
    if (mr) begin
      m_st = 0; m_val = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      case (m_st)
        0: if (start4) begin
             if (d_tens > 4'd9 || d_ones > 4'd9) m_err = 1'b1;
             else begin
               m_val = int'(d_tens) * 10 + int'(d_ones);
               m_cnt = 0; m_err = 1'b0;
               m_st  = (m_val == 0) ? 3 : 1;
             end
           end
        1, 2: if (abort) begin
                m_val = 0; m_cnt = 0; m_st = 0;
              end else if (pause) begin
                m_st = 2;
              end else begin
                m_st = 1;
                m_cnt++;
                if (m_cnt == 4) begin
                  m_cnt = 0;
                  m_val--;
                  if (m_val == 0) m_st = 3;
                end
              end
        default: m_st = 0;
      endcase
      if (sb_on) begin
        x.t = 4'(m_val / 10);
        x.o = 4'(m_val % 10);
        x.b = (m_st == 1 || m_st == 2);
        x.d = (m_st == 3);
        x.e = m_err;
        sb.push_back(x);
      end
    end
  end

  // Pop one expectation per clock and compare against the PRESCALE=4 instance.
  always @(negedge clk) begin
    exp_t w;
    exp_t g;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      g = {q_tens4, q_ones4, busy4, done4, err4};
      total++;
      if (g !== w) begin
        bad++;
        $display("FAIL scoreboard t=%0t got t=%0d o=%0d busy=%b done=%b err=%b want t=%0d o=%0d busy=%b done=%b err=%b",
                 $time, g.t, g.o, g.b, g.d, g.e, w.t, w.o, w.b, w.d, w.e);
      end
    end
  end

  task automatic test_reset();
    #1;
    total++;
    if ({q_tens4, q_ones4, busy4, done4, err4} !== 11'd0) begin
      bad++;
      $display("FAIL reset4 got %h want 000", {q_tens4, q_ones4, busy4, done4, err4});
    end
    total++;
    if ({q_tens1, q_ones1, busy1, done1, err1} !== 11'd0) begin
      bad++;
      $display("FAIL reset1 got %h want 000", {q_tens1, q_ones1, busy1, done1, err1});
    end
    @(negedge clk);
    mr = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic test_reset_midrun();
    d_tens = 4'd3; d_ones = 4'd5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    #2 mr = 1'b1;
    #1;
    total++;
    if ({q_tens4, q_ones4, busy4, done4, err4} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset got %h want 000", {q_tens4, q_ones4, busy4, done4, err4});
    end
    @(negedge clk);
    mr = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    total++;
    if ({q_tens4, q_ones4, busy4} !== {4'd3, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL restart_load got %0d%0d busy=%b want 35 busy=1", q_tens4, q_ones4, busy4);
    end
    repeat (142) @(negedge clk);
  endtask

  task automatic test_borrow();
    d_tens = 4'd1; d_ones = 4'd2; start1 = 1'b1;
    for (int e = 0; e < 14; e++) begin
      int v;
      @(negedge clk);
      start1 = 1'b0;
      v = (e < 12) ? 12 - e : 0;
      total++;
      if ({q_tens1, q_ones1} !== {4'(v / 10), 4'(v % 10)}) begin
        bad++;
        $display("FAIL borrow_digits edge=%0d got %0d%0d want %0d", e, q_tens1, q_ones1, v);
      end
      total++;
      if ({busy1, done1} !== {(e < 12), (e == 12)}) begin
        bad++;
        $display("FAIL borrow_flags edge=%0d got busy=%b done=%b want busy=%b done=%b",
                 e, busy1, done1, (e < 12), (e == 12));
      end
    end
  endtask

  task automatic test_pause();
    int first = -1;
    d_tens = 4'd0; d_ones = 4'd3; start4 = 1'b1;
    for (int e = 0; e < 24; e++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (e == 1) pause = 1'b1;
      if (e == 6) pause = 1'b0;
      if (e == 4) begin
        total++;
        if ({q_tens4, q_ones4, busy4} !== {4'd0, 4'd3, 1'b1}) begin
          bad++;
          $display("FAIL hold_frozen got %0d%0d busy=%b want 03 busy=1", q_tens4, q_ones4, busy4);
        end
      end
      if (done4 === 1'b1 && first < 0) first = e;
    end
    total++;
    if (first != 17) begin
      bad++;
      $display("FAIL pause_done_edge got %0d want 17", first);
    end
  endtask

  task automatic test_abort();
    d_tens = 4'd2; d_ones = 4'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);
    pause = 1'b1; abort = 1'b1;
    @(negedge clk);
    total++;
    if ({q_tens4, q_ones4, busy4, done4} !== 10'd0) begin
      bad++;
      $display("FAIL abort_run got %0d%0d busy=%b done=%b want 00 busy=0 done=0", q_tens4, q_ones4, busy4, done4);
    end
    pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    total++;
    if ({q_tens4, q_ones4, busy4, done4} !== 10'd0) begin
      bad++;
      $display("FAIL abort_hold got %0d%0d busy=%b done=%b want 00 busy=0 done=0", q_tens4, q_ones4, busy4, done4);
    end
    abort = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invalid();
    d_tens = 4'd0; d_ones = 4'd10; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    total++;
    if ({err4, busy4, q_tens4, q_ones4} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL bad_preset got err=%b busy=%b q=%0d%0d want err=1 busy=0 q=00", err4, busy4, q_tens4, q_ones4);
    end
    d_ones = 4'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    total++;
    if ({err4, busy4, done4} !== 3'b001) begin
      bad++;
      $display("FAIL zero_preset got err=%b busy=%b done=%b want err=0 busy=0 done=1", err4, busy4, done4);
    end
    @(negedge clk);
    total++;
    if (done4 !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_width got done=%b want 0", done4);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    d_tens = 4'd2; d_ones = 4'd0; start4 = 1'b1;
    for (int e = 0; e < 86; e++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (e == 9) begin
        d_tens = 4'd0; d_ones = 4'd5; start4 = 1'b1;
      end
      if (e == 10) begin
        total++;
        if ({q_tens4, q_ones4} !== {4'd1, 4'd8}) begin
          bad++;
          $display("FAIL ignored_start got %0d%0d want 18", q_tens4, q_ones4);
        end
      end
      if (done4 === 1'b1 && first < 0) first = e;
    end
    total++;
    if (first != 80) begin
      bad++;
      $display("FAIL busy_start_done_edge got %0d want 80", first);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_borrow();
    test_pause();
    test_abort();
    test_invalid();
    test_back_to_back();
    sb_on = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
